// File: rtl/sbuf_double_buffer_pkg.sv
// Shared types and frame geometry for the double-buffered screen buffer.
package sbuf_double_buffer_pkg;

  localparam int FRAME_WIDTH  = 16;
  localparam int FRAME_HEIGHT = 12;
  localparam int FRAME_AREA   = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int ADDR_W       = $clog2(FRAME_AREA);

  // Display read latency is fixed by the structure: one BRAM cycle plus the output register.
  localparam int READ_LATENCY = 2;

  localparam logic [ADDR_W:0] AREA_LIMIT = FRAME_AREA[ADDR_W:0];

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    KICK,
    RENDERING,
    PENDING
  } sbuf_state_t;

  function automatic logic in_frame(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < AREA_LIMIT;
  endfunction

endpackage

// File: rtl/sbuf_double_buffer_bank.sv
// One frame bank: single-clock simple dual-port RAM, FRAME_AREA x 16, registered 1-cycle read.
module sbuf_double_buffer_bank
  import sbuf_double_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data
);

  rgb565_t mem [FRAME_AREA];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sbuf_double_buffer.sv
// Double-buffered RGB565 screen buffer between the renderer and scan-out, swapping on vsync.
// Define SBUF_STATS_EN to build the frame_count / repeat_count statistics counters.
module sbuf_double_buffer
  import sbuf_double_buffer_pkg::*;
#(
  parameter int KICK_CYCLES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [15:0]       sbuf_data,
  input  logic [ADDR_W-1:0] sbuf_addr,
  input  logic              sbuf_write_enable,
  input  logic              frame_done,
  output logic              render_rst,
  input  logic              vsync_in,
  input  logic [ADDR_W-1:0] display_addr,
  input  logic              display_read_enable,
  output logic [15:0]       display_data,
  output logic              display_valid,
  output logic              front_bank,
  output logic              swapped,
  output logic [15:0]       frame_count,
  output logic [15:0]       repeat_count
);

  localparam int              KICK_W    = $clog2(KICK_CYCLES + 1);
  localparam logic [KICK_W-1:0] LAST_KICK = KICK_W'(KICK_CYCLES - 1);

  sbuf_state_t       state;
  logic [KICK_W-1:0] kick_cnt;
  logic              first_cycle;
  logic              do_swap;
  logic              wr_ok;
  logic              rd_ok;
  logic              rd_pending;
  logic              rd_hit;
  logic              rd_bank;
  logic [15:0]       bank0_q;
  logic [15:0]       bank1_q;

  always_comb begin
    do_swap = 1'b0;
    case (state)
      RENDERING: do_swap = !first_cycle && frame_done && vsync_in;
      PENDING:   do_swap = vsync_in;
      default:   do_swap = 1'b0;
    endcase
  end

  // Renderer writes always land in the back bank; scan-out reads the front bank.
  assign wr_ok = (state == RENDERING) && sbuf_write_enable && in_frame(sbuf_addr);
  assign rd_ok = display_read_enable && in_frame(display_addr);

  sbuf_double_buffer_bank u_bank0 (
    .clk     (clk_in),
    .wr_en   (wr_ok && front_bank),
    .wr_addr (sbuf_addr),
    .wr_data (sbuf_data),
    .rd_en   (rd_ok && !front_bank),
    .rd_addr (display_addr),
    .rd_data (bank0_q)
  );

  sbuf_double_buffer_bank u_bank1 (
    .clk     (clk_in),
    .wr_en   (wr_ok && !front_bank),
    .wr_addr (sbuf_addr),
    .wr_data (sbuf_data),
    .rd_en   (rd_ok && front_bank),
    .rd_addr (display_addr),
    .rd_data (bank1_q)
  );

  // The renderer's frame_done may still be high from the previous frame, so it is
  // not trusted on the first RENDERING cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= KICK;
      kick_cnt    <= '0;
      render_rst  <= 1'b1;
      first_cycle <= 1'b0;
      front_bank  <= 1'b0;
      swapped     <= 1'b0;
    end else begin
      swapped <= do_swap;
      if (do_swap) begin
        front_bank <= ~front_bank;
        state      <= KICK;
        kick_cnt   <= '0;
        render_rst <= 1'b1;
      end else begin
        case (state)
          KICK: begin
            if (kick_cnt == LAST_KICK) begin
              state       <= RENDERING;
              render_rst  <= 1'b0;
              first_cycle <= 1'b1;
            end else begin
              kick_cnt <= kick_cnt + KICK_W'(1);
            end
          end
          RENDERING: begin
            first_cycle <= 1'b0;
            if (!first_cycle && frame_done) state <= PENDING;
          end
          default: ;
        endcase
      end
    end
  end

  // Bank select travels with the read so a swap mid-flight cannot redirect it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_pending    <= 1'b0;
      rd_hit        <= 1'b0;
      rd_bank       <= 1'b0;
      display_valid <= 1'b0;
      display_data  <= '0;
    end else begin
      rd_pending    <= display_read_enable;
      rd_hit        <= rd_ok;
      rd_bank       <= front_bank;
      display_valid <= rd_pending;
      display_data  <= (rd_pending && rd_hit) ? (rd_bank ? bank1_q : bank0_q) : 16'h0000;
    end
  end

`ifdef SBUF_STATS_EN
  logic idle_vsync;
  assign idle_vsync = vsync_in && (state != PENDING) && !do_swap;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_count  <= '0;
      repeat_count <= '0;
    end else begin
      if (do_swap)    frame_count  <= frame_count + 16'd1;
      if (idle_vsync) repeat_count <= repeat_count + 16'd1;
    end
  end
`else
  assign frame_count  = '0;
  assign repeat_count = '0;
`endif

endmodule

// File: tb/tb_sbuf_double_buffer.sv
// Self-checking bench for sbuf_double_buffer: frame-level behavioural model plus directed checks.
module tb_sbuf_double_buffer;
  import sbuf_double_buffer_pkg::*;

  localparam int KICK    = 2;
  localparam int M_KICK   = 0;
  localparam int M_RENDER = 1;
  localparam int M_PEND   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       wd;
  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] ra;
  logic              we, fd, vs, re;
  logic              render_rst, display_valid, front_bank, swapped;
  logic [15:0]       display_data, frame_count, repeat_count;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  always #5 clk = ~clk;

  sbuf_double_buffer #(.KICK_CYCLES(KICK)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .sbuf_data           (wd),
    .sbuf_addr           (wa),
    .sbuf_write_enable   (we),
    .frame_done          (fd),
    .render_rst          (render_rst),
    .vsync_in            (vs),
    .display_addr        (ra),
    .display_read_enable (re),
    .display_data        (display_data),
    .display_valid       (display_valid),
    .front_bank          (front_bank),
    .swapped             (swapped),
    .frame_count         (frame_count),
    .repeat_count        (repeat_count)
  );

  // Frame-level model: which bank is shown, what each bank holds, and what each read returns.
  logic [15:0] mem   [2][FRAME_AREA];
  bit          known [2][FRAME_AREA];
  int          m_phase = M_KICK;
  int          m_kick_left = KICK;
  int          m_frames = 0;
  int          m_repeats = 0;
  bit          m_fresh = 1'b0;
  bit          m_front = 1'b0;
  bit          swap_now = 1'b0;
  bit          rd_v = 1'b0;
  bit          rd_k = 1'b1;
  logic [15:0] rd_d = '0;
  bit          exp_valid = 1'b0;
  bit          exp_known = 1'b1;
  logic [15:0] exp_data = '0;
  bit          exp_swapped = 1'b0;
  bit          exp_render_rst = 1'b1;
  bit          exp_front = 1'b0;
  logic [15:0] exp_frames = '0;
  logic [15:0] exp_repeats = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = M_KICK; m_kick_left = KICK; m_fresh = 1'b0; m_front = 1'b0;
      m_frames = 0; m_repeats = 0; swap_now = 1'b0;
      rd_v = 1'b0; rd_d = '0; rd_k = 1'b1;
      exp_valid = 1'b0; exp_data = '0; exp_known = 1'b1;
    end else begin
      exp_valid = rd_v; exp_data = rd_d; exp_known = rd_k;
      rd_v = re;
      if (int'(ra) < FRAME_AREA) begin
        rd_d = mem[m_front][ra];
        rd_k = known[m_front][ra];
      end else begin
        rd_d = 16'h0000;
        rd_k = 1'b1;
      end
      if (m_phase == M_RENDER && we && int'(wa) < FRAME_AREA) begin
        mem[!m_front][wa]   = wd;
        known[!m_front][wa] = 1'b1;
      end
      swap_now = 1'b0;
      case (m_phase)
        M_KICK: begin
          if (vs) m_repeats++;
          m_kick_left--;
          if (m_kick_left == 0) begin
            m_phase = M_RENDER;
            m_fresh = 1'b1;
          end
        end
        M_RENDER: begin
          if (!m_fresh && fd) begin
            if (vs) swap_now = 1'b1;
            else    m_phase = M_PEND;
          end else if (vs) begin
            m_repeats++;
          end
          m_fresh = 1'b0;
        end
        default: if (vs) swap_now = 1'b1;
      endcase
      if (swap_now) begin
        m_front = !m_front;
        m_phase = M_KICK;
        m_kick_left = KICK;
        m_frames++;
      end
    end
    exp_swapped    = swap_now;
    exp_render_rst = (m_phase == M_KICK);
    exp_front      = m_front;
`ifdef SBUF_STATS_EN
    exp_frames  = 16'(m_frames);
    exp_repeats = 16'(m_repeats);
`else
    exp_frames  = 16'h0000;
    exp_repeats = 16'h0000;
`endif
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("render_rst",    32'(render_rst),    32'(exp_render_rst));
      checkOutput("front_bank",    32'(front_bank),    32'(exp_front));
      checkOutput("swapped",       32'(swapped),       32'(exp_swapped));
      checkOutput("display_valid", 32'(display_valid), 32'(exp_valid));
      if (exp_valid && exp_known)
        checkOutput("display_data", 32'(display_data), 32'(exp_data));
      checkOutput("frame_count",   32'(frame_count),   32'(exp_frames));
      checkOutput("repeat_count",  32'(repeat_count),  32'(exp_repeats));
    end
  end

  task automatic applyStimulus(input logic w_en, input int w_addr, input logic [15:0] w_data,
                               input logic vsync, input logic r_en, input int r_addr);
    we = w_en; wa = w_addr[ADDR_W-1:0]; wd = w_data;
    vs = vsync; re = r_en; ra = r_addr[ADDR_W-1:0];
    @(posedge clk); #1;
    we = 1'b0; vs = 1'b0; re = 1'b0;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 0, 16'h0000, 1'b0, 1'b0, 0);
  endtask

  task automatic waitRendering();
    int n = 0;
    while (render_rst && n < 20) begin
      applyIdle();
      n++;
    end
    if (render_rst) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_rendering: render_rst=%0b after %0d cycles, expected 0", render_rst, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    we = 1'b0; wa = '0; wd = '0; fd = 1'b0; vs = 1'b0; re = 1'b0; ra = '0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < FRAME_AREA; a++) known[b][a] = 1'b0;

    // Reset state, then render_rst high for exactly two cycles.
    rst = 1'b1;
    @(posedge clk); #1;
    check_en = 1'b1;
    checkOutput("reset render_rst", 32'(render_rst), 32'd1);
    checkOutput("reset front_bank", 32'(front_bank), 32'd0);
    checkOutput("reset valid",      32'(display_valid), 32'd0);
    checkOutput("reset data",       32'(display_data), 32'h0);
    checkOutput("reset swapped",    32'(swapped), 32'd0);
    rst = 1'b0;
    applyIdle();
    checkOutput("kick cycle 2", 32'(render_rst), 32'd1);
    applyIdle();
    checkOutput("kick released", 32'(render_rst), 32'd0);

    // Fill bank 1, write 5C29 at 5, finish frame, swap on vsync, read it back.
    for (int i = 0; i < FRAME_AREA; i++)
      applyStimulus(1'b1, i, 16'(32'h1000 + i), 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 5, 16'h5C29, 1'b0, 1'b0, 0);
    fd = 1'b1;
    applyIdle();
    applyIdle();
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 1'b0, 0);
    checkOutput("t2 swapped", 32'(swapped), 32'd1);
    checkOutput("t2 front",   32'(front_bank), 32'd1);
    fd = 1'b0;
    applyStimulus(1'b0, 0, 16'h0000, 1'b0, 1'b1, 5);
    checkOutput("t2 valid early", 32'(display_valid), 32'd0);
    applyIdle();
    checkOutput("t2 valid", 32'(display_valid), 32'd1);
    checkOutput("t2 data",  32'(display_data), 32'h5C29);

    // Fill bank 0 (plus a dropped out-of-range write), then frame_done with vsync together.
    waitRendering();
    for (int i = 0; i < FRAME_AREA; i++)
      applyStimulus(1'b1, i, 16'(32'h2000 + i), 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 250, 16'h1234, 1'b0, 1'b0, 0);
    fd = 1'b1;
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 1'b0, 0);
    checkOutput("t3 swapped",    32'(swapped), 32'd1);
    checkOutput("t3 render_rst", 32'(render_rst), 32'd1);
    checkOutput("t3 front",      32'(front_bank), 32'd0);
    applyStimulus(1'b1, 9, 16'hDEAD, 1'b0, 1'b0, 0);

    // Stale frame_done ignored on first cycle; write in PENDING dropped.
    waitRendering();
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 1'b0, 0);
    checkOutput("t4 stale flag no swap", 32'(swapped), 32'd0);
    applyIdle();
    applyStimulus(1'b1, 7, 16'hFFFF, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 1'b0, 0);
    checkOutput("t4 front", 32'(front_bank), 32'd1);
    fd = 1'b0;
    applyStimulus(1'b0, 0, 16'h0000, 1'b0, 1'b1, 7);
    applyIdle();
    checkOutput("t4 valid", 32'(display_valid), 32'd1);
    checkOutput("t4 data",  32'(display_data), 32'h1007);

    // Read in the swap cycle uses the old front bank; the following read uses the new one.
    waitRendering();
    fd = 1'b1;
    applyIdle();
    applyIdle();
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 1'b1, 9);
    applyStimulus(1'b0, 0, 16'h0000, 1'b0, 1'b1, 9);
    checkOutput("t5 old bank valid", 32'(display_valid), 32'd1);
    checkOutput("t5 old bank data",  32'(display_data), 32'h1009);
    applyStimulus(1'b0, 0, 16'h0000, 1'b0, 1'b1, 200);
    checkOutput("t5 new bank data",  32'(display_data), 32'h2009);
    fd = 1'b0;
    applyIdle();
    checkOutput("t5 oob valid", 32'(display_valid), 32'd1);
    checkOutput("t5 oob data",  32'(display_data), 32'h0);

    // Statistics from a clean reset: three idle vsyncs and one swap.
    rst = 1'b1;
    applyIdle();
    rst = 1'b0;
    checkOutput("t6 reset frames", 32'(frame_count), 32'd0);
    waitRendering();
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 1'b0, 0);
    applyIdle();
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 1'b0, 0);
    applyIdle();
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 1'b0, 0);
    fd = 1'b1;
    applyIdle();
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 1'b0, 0);
    fd = 1'b0;
`ifdef SBUF_STATS_EN
    checkOutput("t6 frame_count",  32'(frame_count), 32'd1);
    checkOutput("t6 repeat_count", 32'(repeat_count), 32'd3);
`else
    checkOutput("t6 frame_count",  32'(frame_count), 32'd0);
    checkOutput("t6 repeat_count", 32'(repeat_count), 32'd0);
`endif
    checkOutput("t6 front", 32'(front_bank), 32'd1);

    // Reset with a read in flight discards it and returns to bank 0.
    applyStimulus(1'b0, 0, 16'h0000, 1'b0, 1'b1, 5);
    rst = 1'b1;
    applyIdle();
    checkOutput("mid reset valid",      32'(display_valid), 32'd0);
    checkOutput("mid reset front",      32'(front_bank), 32'd0);
    checkOutput("mid reset render_rst", 32'(render_rst), 32'd1);
    checkOutput("mid reset repeats",    32'(repeat_count), 32'd0);
    rst = 1'b0;
    repeat (3) applyIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
